// File: rtl/bcd_display_scheduler.sv
// rtl/bcd_display_scheduler.sv - two-channel shared shift-add-3 binary-to-BCD display scheduler
//
// Ports:
//   clock                      system clock, rising edge
//   reset                      asynchronous active-low reset
//   req[1:0]                   level request per channel, held until its grant pulses
//   bin0, bin1                 channel operands, captured on the granting edge
//   grant[1:0]                 one-cycle grant pulse for the captured channel
//   busy                       conversion in progress (SHIFT or STORE)
//   done                       one-cycle pulse when a channel's digits update
//   tens0/ones0, tens1/ones1   registered digit codes per channel
//   ovf0, ovf1                 last conversion for the channel was >= 100
module bcd_display_scheduler #(
  parameter int         WIDTH      = 7,
  parameter logic [3:0] DASH_CODE  = 4'b0101,
  parameter logic [3:0] BLANK_CODE = 4'b0100
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] bin0,
  input  logic [WIDTH-1:0] bin1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done,
  output logic [3:0]       tens0,
  output logic [3:0]       ones0,
  output logic [3:0]       tens1,
  output logic [3:0]       ones1,
  output logic             ovf0,
  output logic             ovf1
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Operand values that carry display meaning instead of a number.
  localparam logic [WIDTH-1:0] DASH_OP  = '1;
  localparam logic [WIDTH-1:0] BLANK_OP = {{(WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SHIFT, STORE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr;        // operand being shifted out MSB first
  logic [WIDTH-1:0] op;        // untouched copy for special-code detection
  logic [3:0]       hun, ten, one;
  logic [3:0]       ten_a, one_a;
  logic [CW-1:0]    cnt;
  logic             ch;        // channel owning the current conversion
  logic             last;      // channel granted most recently
  logic             start;
  logic             pick;

  logic [3:0]       st_tens, st_ones;
  logic             st_ovf;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    pick     = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          start    = 1'b1;
          state_nx = SHIFT;
          // Contention goes to whoever did not win last time.
          if (req == 2'b11) pick = ~last;
          else              pick = req[1];
        end
      end
      SHIFT: begin
        if (cnt == '0) state_nx = STORE;
      end
      STORE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Hundreds never reaches 5 for a 7-bit operand, so it needs no correction.
  assign ten_a = (ten >= 4'd5) ? ten + 4'd3 : ten;
  assign one_a = (one >= 4'd5) ? one + 4'd3 : one;

  always_comb begin
    st_tens = ten;
    st_ones = one;
    st_ovf  = (hun != 4'd0);
    if (op == DASH_OP) begin
      st_tens = DASH_CODE;
      st_ones = DASH_CODE;
      st_ovf  = 1'b0;
    end else if (op == BLANK_OP) begin
      st_tens = BLANK_CODE;
      st_ones = BLANK_CODE;
      st_ovf  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant <= 2'b00;
      busy  <= 1'b0;
      done  <= 1'b0;
      tens0 <= BLANK_CODE;
      ones0 <= BLANK_CODE;
      tens1 <= BLANK_CODE;
      ones1 <= BLANK_CODE;
      ovf0  <= 1'b0;
      ovf1  <= 1'b0;
      last  <= 1'b1;             // so channel 0 wins the first contention
      ch    <= 1'b0;
      sr    <= '0;
      op    <= '0;
      hun   <= 4'd0;
      ten   <= 4'd0;
      one   <= 4'd0;
      cnt   <= '0;
    end else begin
      grant <= 2'b00;
      done  <= 1'b0;
      busy  <= (state_nx != IDLE);

      if (start) begin
        ch    <= pick;
        last  <= pick;
        grant <= pick ? 2'b10 : 2'b01;
        sr    <= pick ? bin1 : bin0;
        op    <= pick ? bin1 : bin0;
        hun   <= 4'd0;
        ten   <= 4'd0;
        one   <= 4'd0;
        cnt   <= CW'(WIDTH - 1);
      end

      if (state == SHIFT) begin
        hun <= {hun[2:0], ten_a[3]};
        ten <= {ten_a[2:0], one_a[3]};
        one <= {one_a[2:0], sr[WIDTH-1]};
        sr  <= {sr[WIDTH-2:0], 1'b0};
        cnt <= cnt - 1'b1;
      end

      if (state == STORE) begin
        done <= 1'b1;
        if (ch) begin
          tens1 <= st_tens;
          ones1 <= st_ones;
          ovf1  <= st_ovf;
        end else begin
          tens0 <= st_tens;
          ones0 <= st_ones;
          ovf0  <= st_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// tb/tb_bcd_display_scheduler.sv - scoreboard bench for bcd_display_scheduler
module tb_bcd_display_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req   = 2'b00;
  logic [6:0] bin0  = 7'd0;
  logic [6:0] bin1  = 7'd0;
  logic [1:0] grant;
  logic       busy, done;
  logic [3:0] tens0, ones0, tens1, ones1;
  logic       ovf0, ovf1;

  bcd_display_scheduler dut (
    .clock(clock), .reset(reset), .req(req), .bin0(bin0), .bin1(bin1),
    .grant(grant), .busy(busy), .done(done),
    .tens0(tens0), .ones0(ones0), .tens1(tens1), .ones1(ones1),
    .ovf0(ovf0), .ovf1(ovf1)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] t0, o0, t1, o1;
    logic       v0, v1;
    int         gcyc;
  } item_t;

  item_t sb_q[$];

  // Display model and per-channel expected result of the pending operand.
  logic [3:0] m_t[2], m_o[2];
  logic       m_v[2];
  logic [3:0] e_t[2], e_o[2];
  logic       e_v[2];
  int         prev_g = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 4'b0100;
      m_o[i] = 4'b0100;
      m_v[i] = 1'b0;
    end
    sb_q.delete();
    prev_g = -1;
  endtask

  // Grant watcher: each grant is the moment a conversion is issued.
  always @(negedge clock) begin
    if (reset && grant != 2'b00) begin
      item_t it;
      int c;
      chk("grant_onehot", int'(grant == 2'b01 || grant == 2'b10), 1);
      chk("busy_at_grant", busy, 1);
      c = grant[1] ? 1 : 0;
      m_t[c] = e_t[c];
      m_o[c] = e_o[c];
      m_v[c] = e_v[c];
      if (prev_g >= 0) chk("grant_spacing_min", int'(cyc - prev_g >= 9), 1);
      prev_g = cyc;
      it.t0 = m_t[0]; it.o0 = m_o[0]; it.v0 = m_v[0];
      it.t1 = m_t[1]; it.o1 = m_o[1]; it.v1 = m_v[1];
      it.gcyc = cyc;
      sb_q.push_back(it);
    end
  end

  // Monitor: compares the whole display whenever done pulses.
  always @(negedge clock) begin
    if (reset && done) begin
      item_t it;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        it = sb_q.pop_front();
        chk("done_latency", cyc - it.gcyc, 8);
        chk("tens0", tens0, it.t0);
        chk("ones0", ones0, it.o0);
        chk("ovf0", ovf0, it.v0);
        chk("tens1", tens1, it.t1);
        chk("ones1", ones1, it.o1);
        chk("ovf1", ovf1, it.v1);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic wait_grant(input int c, output int gc);
    int n;
    n  = 0;
    gc = -1;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (grant[c]) begin
        gc = cyc;
        break;
      end
    end
    checks++;
    if (gc < 0) begin
      errors++;
      $display("FAIL grant_timeout ch%0d: no grant within %0d cycles", c, n);
    end
  endtask

  task automatic run_one(input int c, input logic [6:0] val,
                         input logic [3:0] t, input logic [3:0] o, input logic v);
    int g;
    e_t[c] = t;
    e_o[c] = o;
    e_v[c] = v;
    if (c == 0) bin0 = val;
    else        bin1 = val;
    req[c] = 1'b1;
    wait_grant(c, g);
    req[c] = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_tens0"}, tens0, 4'b0100);
    chk({tag, "_ones0"}, ones0, 4'b0100);
    chk({tag, "_tens1"}, tens1, 4'b0100);
    chk({tag, "_ones1"}, ones1, 4'b0100);
    chk({tag, "_ovf"}, {ovf1, ovf0}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_grant"}, grant, 0);
  endtask

  initial begin
    int g1, g2, n;
    model_clear();
    for (int i = 0; i < 2; i++) begin
      e_t[i] = 4'b0100; e_o[i] = 4'b0100; e_v[i] = 1'b0;
    end

    // Reset state, then abort a conversion by resetting mid-SHIFT.
    repeat (3) @(negedge clock);
    chk_blank("in_reset");
    reset = 1'b1;
    @(negedge clock);
    chk_blank("after_reset");
    e_t[0] = 4'd4; e_o[0] = 4'd5; e_v[0] = 1'b0;
    bin0 = 7'd45;
    req  = 2'b01;
    wait_grant(0, g1);
    req = 2'b00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    repeat (12) @(negedge clock);
    chk_blank("abort");

    // Single conversions with hand-computed digits.
    run_one(0, 7'd45,  4'd4, 4'd5, 1'b0);
    run_one(1, 7'd125, 4'd2, 4'd5, 1'b1);
    run_one(1, 7'd99,  4'd9, 4'd9, 1'b0);
    run_one(0, 7'h7F,  4'b0101, 4'b0101, 1'b0);
    run_one(0, 7'h7E,  4'b0100, 4'b0100, 1'b0);
    run_one(1, 7'd100, 4'd0, 4'd0, 1'b1);
    run_one(0, 7'd0,   4'd0, 4'd0, 1'b0);
    run_one(1, 7'd126 - 7'd1, 4'd2, 4'd5, 1'b1);

    // Operand change after grant is ignored; held req gives back-to-back grant.
    e_t[0] = 4'd4; e_o[0] = 4'd5; e_v[0] = 1'b0;
    bin0 = 7'd45;
    req  = 2'b01;
    wait_grant(0, g1);
    @(negedge clock);
    bin0   = 7'd99;
    e_t[0] = 4'd9; e_o[0] = 4'd9; e_v[0] = 1'b0;
    wait_grant(0, g2);
    req = 2'b00;
    chk("back_to_back_spacing", g2 - g1, 9);
    repeat (12) @(negedge clock);

    // Both channels held after reset: grants alternate starting with channel 0.
    pulse_reset();
    e_t[0] = 4'd1; e_o[0] = 4'd2; e_v[0] = 1'b0;
    e_t[1] = 4'd3; e_o[1] = 4'd4; e_v[1] = 1'b0;
    bin0 = 7'd12;
    bin1 = 7'd34;
    req  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (grant == 2'b00 && n < 40);
      chk($sformatf("alt_grant_%0d", i), grant, (i % 2 == 0) ? 1 : 2);
    end
    req = 2'b00;
    repeat (12) @(negedge clock);

    chk("queue_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
